// File: rtl/alu_result_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_result_queue
//  Purpose  : In-order result buffer behind the integer ALU. Each 32-bit
//             result is stored with the 4-bit opcode tag that produced it in a
//             small circular FIFO. Results are presented first-word-fall-through
//             to the writeback consumer. O_full provides pipe_full back-pressure
//             to dispatch.
//  Ports    : clk          core clock, rising edge
//             rst          asynchronous active-low reset
//             I_data/I_tag ALU result word and its opcode tag
//             I_push       enqueue I_data/I_tag this cycle
//             I_pop        dequeue the head entry this cycle
//             I_flush      synchronous clear of all entries (flags kept)
//             O_data/O_tag head entry, forced to 0 while empty
//             O_ctrl       head valid (queue non-empty)
//             O_full       occupancy == DEPTH
//             O_count      occupancy 0..DEPTH
//             O_overflow   sticky: a push was dropped
//             O_underflow  sticky: a pop arrived while empty
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_queue #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4    // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        I_data,
  input  logic [TAG_W-1:0]         I_tag,
  input  logic                     I_push,
  input  logic                     I_pop,
  input  logic                     I_flush,
  output logic [DATA_W-1:0]        O_data,
  output logic [TAG_W-1:0]         O_tag,
  output logic                     O_ctrl,
  output logic                     O_full,
  output logic [$clog2(DEPTH):0]   O_count,
  output logic                     O_overflow,
  output logic                     O_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + TAG_W;

  // Storage is not reset; count gates every read so stale words never leak.
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;

  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic             wr_en;
  logic [ENT_W-1:0] head;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    pop_ok   = I_pop && !empty;
    // A pop on the same edge frees a slot, so a full queue still accepts.
    push_ok  = I_push && (!full || pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    wr_en    = 1'b0;

    if (I_flush) begin
      // Flush discards same-cycle traffic; error history is preserved.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en = push_ok;
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);   // power-of-two depth wraps naturally
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (I_push && !push_ok) begin
        ovf_d = 1'b1;
      end
      if (I_pop && empty) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals the old rd_ptr, so the
  // new entry lands in the slot being vacated; the old head is read this cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {I_tag, I_data};
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign O_ctrl      = !empty;
  assign O_data      = empty ? '0 : head[DATA_W-1:0];
  assign O_tag       = empty ? '0 : head[ENT_W-1:DATA_W];
  assign O_full      = full;
  assign O_count     = count_q;
  assign O_overflow  = ovf_q;
  assign O_underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_queue
//  Purpose  : Self-checking bench for alu_result_queue. A queue-based model
//             tracks expected contents; a negedge monitor compares the DUT
//             head and status against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_queue;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [DATA_W-1:0]      I_data = '0;
  logic [TAG_W-1:0]       I_tag = '0;
  logic                   I_push = 1'b0;
  logic                   I_pop = 1'b0;
  logic                   I_flush = 1'b0;
  logic [DATA_W-1:0]      O_data;
  logic [TAG_W-1:0]       O_tag;
  logic                   O_ctrl;
  logic                   O_full;
  logic [$clog2(DEPTH):0] O_count;
  logic                   O_overflow;
  logic                   O_underflow;

  alu_result_queue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .I_data(I_data), .I_tag(I_tag),
    .I_push(I_push), .I_pop(I_pop), .I_flush(I_flush),
    .O_data(O_data), .O_tag(O_tag), .O_ctrl(O_ctrl),
    .O_full(O_full), .O_count(O_count),
    .O_overflow(O_overflow), .O_underflow(O_underflow)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
  } ent_t;

  // Reference model: queue of entries accepted so far plus status.
  ent_t exp_q[$];
  int   exp_cnt = 0;
  bit   exp_ovf = 1'b0;
  bit   exp_unf = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the model away from the active edge and
  // retires the model head whenever the consumer takes it.
  always @(negedge clk) begin
    chk("count",     64'(O_count),     64'(exp_cnt));
    chk("full",      64'(O_full),      64'(exp_cnt == DEPTH));
    chk("ctrl",      64'(O_ctrl),      64'(exp_cnt != 0));
    chk("overflow",  64'(O_overflow),  64'(exp_ovf));
    chk("underflow", 64'(O_underflow), 64'(exp_unf));
    if (exp_q.size() > 0) begin
      chk("head_data", 64'(O_data), 64'(exp_q[0].d));
      chk("head_tag",  64'(O_tag),  64'(exp_q[0].t));
      if (rst && I_pop && !I_flush) begin
        void'(exp_q.pop_front());
      end
    end else begin
      chk("empty_data", 64'(O_data), 64'd0);
      chk("empty_tag",  64'(O_tag),  64'd0);
    end
  end

  // One clock of stimulus; the model's view of the state is updated after the edge.
  task automatic step(input bit push, input bit pop, input bit flush,
                      input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    bit   pop_ok;
    bit   push_ok;
    ent_t e;
    I_push = push; I_pop = pop; I_flush = flush; I_data = d; I_tag = t;
    @(posedge clk);
    #1;
    if (flush) begin
      exp_cnt = 0;
      exp_q.delete();
    end else begin
      pop_ok  = pop && (exp_cnt > 0);
      push_ok = push && ((exp_cnt < DEPTH) || pop_ok);
      if (push && !push_ok) exp_ovf = 1'b1;
      if (pop && exp_cnt == 0) exp_unf = 1'b1;
      if (push_ok) begin
        e.d = d;
        e.t = t;
        exp_q.push_back(e);
      end
      exp_cnt = exp_cnt + int'(push_ok) - int'(pop_ok);
    end
    I_push = 1'b0; I_pop = 1'b0; I_flush = 1'b0;
  endtask

  task automatic model_reset();
    exp_cnt = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single push then pop.
    step(1, 0, 0, 32'h0000_00A5, 4'h3);
    step(0, 1, 0, '0, '0);
    step(0, 0, 0, '0, '0);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 32'(i * 'h11), 4'(i));
    step(1, 0, 0, 32'h55, 4'h5);
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0);

    // Full with simultaneous push+pop: pointers wrap, 0x66 drains last.
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 32'(i * 'h11), 4'(i + 8));
    step(1, 1, 0, 32'h66, 4'h6);
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0);

    // Streaming push+pop pairs from empty.
    step(1, 0, 0, 32'd1, 4'd1);
    for (int i = 2; i <= 10; i++) step(1, 1, 0, 32'(i), 4'(i));
    step(0, 1, 0, '0, '0);

    // Pop while empty, flag survives idle cycles and flush.
    step(0, 1, 0, '0, '0);
    repeat (5) step(0, 0, 0, '0, '0);
    step(1, 0, 0, 32'hBEEF, 4'hE);
    step(0, 0, 1, '0, '0);
    step(0, 0, 0, '0, '0);

    // Asynchronous reset between edges with 3 entries loaded.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h100 + 32'(i), 4'(i));
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_ctrl",  64'(O_ctrl),      64'd0);
    chk("arst_count", 64'(O_count),     64'd0);
    chk("arst_data",  64'(O_data),      64'd0);
    chk("arst_tag",   64'(O_tag),       64'd0);
    chk("arst_full",  64'(O_full),      64'd0);
    chk("arst_unf",   64'(O_underflow), 64'd0);
    #2 rst = 1'b1;
    step(1, 0, 0, 32'h77, 4'h7);
    step(0, 0, 0, '0, '0);
    step(0, 1, 0, '0, '0);

    // Randomized traffic; flush never overlaps push/pop.
    for (int i = 0; i < 600; i++) begin
      bit fl;
      bit pu;
      bit po;
      int mode;
      mode = (i / 100) % 3;   // phases biased toward filling, balanced, draining
      fl = ($urandom_range(0, 99) < 3);
      pu = !fl && ($urandom_range(0, 99) < (mode == 0 ? 80 : (mode == 1 ? 50 : 25)));
      po = !fl && ($urandom_range(0, 99) < (mode == 0 ? 25 : (mode == 1 ? 50 : 80)));
      step(pu, po, fl, DATA_W'($urandom), TAG_W'($urandom));
    end
    step(0, 0, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
